// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU command sequencer.
// Default widths, latency and ALU control codes.
package alu_seq_pkg;
  localparam int DATA_W    = 16;
  localparam int RES_W     = 38;
  localparam int LATENCY   = 3;
  localparam int RES_DEPTH = 4;

  localparam logic [1:0] CTRL_OP0  = 2'b00;
  localparam logic [1:0] CTRL_OP1  = 2'b01;
  localparam logic [1:0] CTRL_OP2  = 2'b10;
  localparam logic [1:0] CTRL_RSVD = 2'b11;
endpackage

// File: rtl/alu_cmd_sequencer_result_fifo.sv
// First-word fall-through result buffer.
// Push while full is honoured only alongside a pop.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 38,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_rd;
  logic          w_wr;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_rd    = i_pop & ~w_empty;
  assign w_wr    = i_push & (~w_full | w_rd);

  assign o_valid = ~w_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= nxt(r_wr_ptr);
      if (w_rd) r_rd_ptr <= nxt(r_rd_ptr);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Drives operand commands into a fixed-latency ALU
// and buffers its results under credit flow control.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W    = alu_seq_pkg::DATA_W,
  parameter int RES_W     = alu_seq_pkg::RES_W,
  parameter int LATENCY   = alu_seq_pkg::LATENCY,
  parameter int RES_DEPTH = alu_seq_pkg::RES_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_control,
  input  logic [DATA_W-1:0] cmd_in1,
  input  logic [DATA_W-1:0] cmd_in2,
  output logic [1:0]        alu_control,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [RES_W-1:0]  alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              busy,
  output logic [7:0]        issued_count
);

  localparam int CW = $clog2(RES_DEPTH + 1);

  logic [CW-1:0]      r_credits;
  logic [LATENCY-1:0] r_tag;
  logic [1:0]         r_ctl;
  logic [DATA_W-1:0]  r_in1;
  logic [DATA_W-1:0]  r_in2;
  logic [7:0]         r_issued;
  logic               w_accept;
  logic               w_pop;
  logic               w_valid;
  logic [CW-1:0]      w_count;

  assign cmd_ready    = (r_credits != '0) & ~reset;
  assign w_accept     = cmd_valid & cmd_ready;
  assign w_pop        = w_valid & res_ready;
  assign res_valid    = w_valid;
  assign alu_control  = r_ctl;
  assign alu_in1      = r_in1;
  assign alu_in2      = r_in2;
  assign issued_count = r_issued;
  assign busy         = (|r_tag) | (w_count != '0);

  // A credit is one FIFO slot reserved from accept until pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits <= CW'(RES_DEPTH);
    end else if (w_accept & ~w_pop) begin
      r_credits <= r_credits - 1'b1;
    end else if (w_pop & ~w_accept) begin
      r_credits <= r_credits + 1'b1;
    end
  end

  // Operand registers hold the last accepted command.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctl <= '0;
      r_in1 <= '0;
      r_in2 <= '0;
    end else if (w_accept) begin
      r_ctl <= cmd_control;
      r_in1 <= cmd_in1;
      r_in2 <= cmd_in2;
    end
  end

  // Tag pipe marks which ALU output cycles carry our results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Accepted-command counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issued <= '0;
    end else if (w_accept) begin
      r_issued <= r_issued + 8'd1;
    end
  end

  result_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (RES_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_tag[LATENCY-1]),
    .i_data  (alu_result),
    .i_pop   (res_ready),
    .o_valid (w_valid),
    .o_data  (res_data),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a
// multiplying ALU stub.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_control;
  logic [15:0] cmd_in1;
  logic [15:0] cmd_in2;
  logic [1:0]  alu_control;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [37:0] alu_result;
  logic        res_valid;
  logic        res_ready;
  logic [37:0] res_data;
  logic        busy;
  logic [7:0]  issued_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // ALU stub: input load is the first latency edge,
  // two more register stages follow.
  logic [31:0] w_prod;
  logic [37:0] r_d1;
  logic [37:0] r_d2;
  assign w_prod = 32'(alu_in1) * 32'(alu_in2);
  always_ff @(posedge clk) begin
    r_d1 <= {6'b0, w_prod};
    r_d2 <= r_d1;
  end
  assign alu_result = r_d2;

  alu_cmd_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_control  (cmd_control),
    .cmd_in1      (cmd_in1),
    .cmd_in2      (cmd_in2),
    .alu_control  (alu_control),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_result   (alu_result),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .busy         (busy),
    .issued_count (issued_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    cmd_control = CTRL_OP0;
    cmd_in1 = '0;
    cmd_in2 = '0;
    repeat (5) tick();
    checks++;
    if (cmd_ready !== 1'b0)
      $display("FAIL rst_ready got %b want 0", cmd_ready);
    if (cmd_ready !== 1'b0) errors++;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags valid=%b busy=%b want 0 0",
               res_valid, busy);
    end
    checks++;
    if (issued_count !== 8'd0 || alu_in1 !== 16'd0 ||
        alu_in2 !== 16'd0 || alu_control !== 2'd0) begin
      errors++;
      $display("FAIL rst_regs cnt=%0d in1=%0h in2=%0h ctl=%0d want 0",
               issued_count, alu_in1, alu_in2, alu_control);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_single();
    cmd_control = CTRL_OP0;
    cmd_in1 = 16'd2;
    cmd_in2 = 16'd2;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (alu_in1 !== 16'd2 || alu_in2 !== 16'd2 ||
        issued_count !== 8'd1) begin
      errors++;
      $display("FAIL single_load in1=%0d in2=%0d cnt=%0d want 2 2 1",
               alu_in1, alu_in2, issued_count);
    end
    tick();
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got valid=%b want 0", res_valid);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 38'd4) begin
      errors++;
      $display("FAIL single_result valid=%b data=%0h want 1 4",
               res_valid, res_data);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 38'd4) begin
        errors++;
        $display("FAIL single_hold%0d valid=%b data=%0h want 1 4",
                 i, res_valid, res_data);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pop valid=%b busy=%b want 0 0",
               res_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int exp_q[4] = '{4, 9, 16, 25};
    res_ready = 1'b0;
    cmd_control = CTRL_OP1;
    for (int n = 1; n <= 4; n++) begin
      cmd_valid = 1'b1;
      cmd_in1 = 16'(n);
      cmd_in2 = 16'(n);
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d got %b want 1", n, cmd_ready);
      end
      tick();
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall got %b want 0", cmd_ready);
    end
    cmd_in1 = 16'd5;
    cmd_in2 = 16'd5;
    repeat (6) tick();
    checks++;
    if (alu_in1 !== 16'd4 || issued_count !== 8'd5 ||
        res_valid !== 1'b1 || res_data !== 38'd1) begin
      errors++;
      $display("FAIL b2b_full in1=%0d cnt=%0d v=%b d=%0h want 4 5 1 1",
               alu_in1, issued_count, res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || res_data !== 38'd4) begin
      errors++;
      $display("FAIL b2b_credit ready=%b data=%0h want 1 4",
               cmd_ready, res_data);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (alu_in1 !== 16'd5 || issued_count !== 8'd6 ||
        cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fifth in1=%0d cnt=%0d rdy=%b want 5 6 0",
               alu_in1, issued_count, cmd_ready);
    end
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      while (res_valid !== 1'b1 && w < 10) begin
        tick();
        w++;
      end
      checks++;
      if (res_valid !== 1'b1 || res_data !== 38'(exp_q[k])) begin
        errors++;
        $display("FAIL b2b_pop%0d valid=%b data=%0h want 1 %0h",
                 k, res_valid, res_data, exp_q[k]);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_full_concurrent();
    logic [37:0] got[$];
    int idx = 0;
    int cyc = 0;
    logic acc;
    res_ready = 1'b0;
    for (int n = 10; n < 14; n++) begin
      cmd_valid = 1'b1;
      cmd_control = 2'(n);
      cmd_in1 = 16'(n);
      cmd_in2 = 16'(n + 1);
      tick();
    end
    cmd_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_state ready=%b valid=%b want 0 1",
               cmd_ready, res_valid);
    end
    res_ready = 1'b1;
    got.push_back(res_data);
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_first_pop ready=%b want 1", cmd_ready);
    end
    while ((idx < 8 || got.size() < 12) && cyc < 100) begin
      cmd_valid = (idx < 8);
      cmd_control = 2'(idx);
      cmd_in1 = 16'(20 + idx);
      cmd_in2 = 16'(21 + idx);
      #1;
      acc = cmd_valid & cmd_ready;
      if (res_valid === 1'b1) got.push_back(res_data);
      tick();
      if (acc) idx++;
      cyc++;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (got.size() != 12 || idx != 8) begin
      errors++;
      $display("FAIL full_count got %0d results %0d issues want 12 8",
               got.size(), idx);
    end
    for (int k = 0; k < 12 && k < got.size(); k++) begin
      int n;
      n = (k < 4) ? 10 + k : 16 + k;
      checks++;
      if (got[k] !== 38'(n * (n + 1))) begin
        errors++;
        $display("FAIL full_order%0d got %0h want %0h",
                 k, got[k], n * (n + 1));
      end
    end
    checks++;
    if (alu_control !== CTRL_RSVD || issued_count !== 8'd18 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL full_end ctl=%0d cnt=%0d busy=%b want 3 18 0",
               alu_control, issued_count, busy);
    end
  endtask

  task automatic test_reset_midflight();
    cmd_valid = 1'b1;
    cmd_control = CTRL_OP2;
    cmd_in1 = 16'd3;
    cmd_in2 = 16'd3;
    tick();
    cmd_in1 = 16'd5;
    cmd_in2 = 16'd5;
    tick();
    reset = 1'b1;
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_ready got %b want 0", cmd_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (issued_count !== 8'd0 || busy !== 1'b0 ||
        cmd_ready !== 1'b1 || alu_in1 !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst_state cnt=%0d busy=%b rdy=%b in1=%0d want 0 0 1 0",
               issued_count, busy, cmd_ready, alu_in1);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale%0d valid=%b busy=%b want 0 0",
                 i, res_valid, busy);
      end
    end
  endtask

  task automatic test_wrap();
    int cnt = 0;
    int cyc = 0;
    logic acc;
    res_ready = 1'b1;
    cmd_control = CTRL_OP0;
    cmd_in1 = 16'd1;
    cmd_in2 = 16'd1;
    while (cnt < 256 && cyc < 1000) begin
      cmd_valid = 1'b1;
      acc = cmd_ready;
      tick();
      if (acc) cnt++;
      cyc++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (cnt != 256 || issued_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_256 accepts=%0d cnt=%0d want 256 0",
               cnt, issued_count);
    end
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (issued_count !== 8'd1) begin
      errors++;
      $display("FAIL wrap_257 cnt=%0d want 1", issued_count);
    end
    repeat (10) tick();
    res_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_drain busy=%b valid=%b want 0 0",
               busy, res_valid);
    end
  endtask

  task automatic test_wide();
    int w;
    res_ready = 1'b0;
    cmd_control = CTRL_OP2;
    cmd_in1 = 16'h0700;
    cmd_in2 = 16'h0001;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    w = 0;
    while (res_valid !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 38'h700) begin
      errors++;
      $display("FAIL wide_700 valid=%b data=%0h want 1 700",
               res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    cmd_control = CTRL_RSVD;
    cmd_in1 = 16'hFFFF;
    cmd_in2 = 16'hFFFF;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (alu_control !== 2'b11) begin
      errors++;
      $display("FAIL wide_rsvd ctl=%0d want 3", alu_control);
    end
    w = 0;
    while (res_valid !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 38'hFFFE0001) begin
      errors++;
      $display("FAIL wide_max valid=%b data=%0h want 1 fffe0001",
               res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_concurrent();
    test_reset_midflight();
    test_wrap();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
